// File: rtl/sam_arith_dispatch.sv
// Opcode dispatcher: decodes a 16-bit opcode, issues operands from an
// 8-entry register file to an external arithmetic unit and writes the result back.
module sam_arith_dispatch #(
  parameter int TGT_BITS = 32
) (
  input  logic                clk,
  input  logic                rsta,
  input  logic                opValid,
  input  logic [15:0]         opcode,
  output logic                opReady,
  output logic                arithGo,
  output logic [4:0]          arithSubOp,
  output logic [TGT_BITS-1:0] arithLeft,
  output logic [TGT_BITS-1:0] arithRite,
  input  logic [TGT_BITS:0]   arithWord,
  input  logic                arithCarry,
  output logic                done,
  output logic                illegal,
  output logic                carryF,
  output logic                zeroF,
  input  logic                regWrEn,
  input  logic [2:0]          regWrAddr,
  input  logic [TGT_BITS-1:0] regWrData,
  input  logic [2:0]          regRdAddr,
  output logic [TGT_BITS-1:0] regRdData
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WB} state_t;

  localparam logic [4:0] LEGAL_TAG = 5'b11000;
  localparam logic [4:0] SUB_CMP   = 5'd4;

  state_t              state_q, state_d;
  logic [2:0]          dreg_q, sreg_q;
  logic [4:0]          subop_q;
  logic [TGT_BITS-1:0] left_q, rite_q;
  logic                illegal_q, carry_q, zero_q;
  logic [TGT_BITS-1:0] regs_q [8];
  logic [7:0]          reg_we;
  logic [TGT_BITS-1:0] reg_wdata [8];

  logic [2:0] op_dreg, op_sreg;
  logic [4:0] op_subop, op_tag;
  logic       op_legal, accept, host_wr, wb_wr;

  // The top bit of the arithmetic word is not part of the result; carry comes from arithCarry.
  logic unused_word_msb;
  assign unused_word_msb = arithWord[TGT_BITS];

  assign op_dreg  = opcode[15:13];
  assign op_subop = opcode[12:8];
  assign op_sreg  = opcode[7:5];
  assign op_tag   = opcode[4:0];
  assign op_legal = (op_tag == LEGAL_TAG) && !op_subop[4];

  assign opReady = (state_q == IDLE) && !rsta;
  assign accept  = opValid && opReady;
  assign host_wr = regWrEn && (state_q == IDLE) && !rsta;
  assign wb_wr   = (state_q == WAIT) && (subop_q != SUB_CMP);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && op_legal) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rsta) begin
      state_q   <= IDLE;
      dreg_q    <= '0;
      sreg_q    <= '0;
      subop_q   <= '0;
      left_q    <= '0;
      rite_q    <= '0;
      illegal_q <= 1'b0;
      carry_q   <= 1'b0;
      zero_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= accept && !op_legal;
      if (accept) begin
        dreg_q  <= op_dreg;
        subop_q <= op_subop;
        sreg_q  <= op_sreg;
      end
      // Operands are frozen at the end of ISSUE so the write-back cannot disturb them.
      if (state_q == ISSUE) begin
        left_q <= regs_q[0];
        rite_q <= regs_q[sreg_q];
      end
      if (state_q == WAIT) begin
        carry_q <= arithCarry;
        zero_q  <= (arithWord[TGT_BITS-1:0] == '0);
      end
    end
  end

  // Host writes and write-back never coincide: host writes are only honoured in IDLE.
  for (genvar gi = 0; gi < 8; gi++) begin : g_reg_wr
    assign reg_we[gi]    = (host_wr && (regWrAddr == 3'(gi))) || (wb_wr && (dreg_q == 3'(gi)));
    assign reg_wdata[gi] = host_wr ? regWrData : arithWord[TGT_BITS-1:0];
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (rsta) begin
        regs_q[i] <= '0;
      end else if (reg_we[i]) begin
        regs_q[i] <= reg_wdata[i];
      end
    end
  end

  assign regRdData = regs_q[regRdAddr];

  assign arithGo    = (state_q == ISSUE) && !rsta;
  assign done       = (state_q == WB) && !rsta;
  assign illegal    = illegal_q && !rsta;
  assign carryF     = carry_q && !rsta;
  assign zeroF      = zero_q && !rsta;
  assign arithSubOp = ((state_q != IDLE) && !rsta) ? subop_q : 5'd0;

  always_comb begin
    arithLeft = '0;
    arithRite = '0;
    if (!rsta) begin
      if (state_q == ISSUE) begin
        arithLeft = regs_q[0];
        arithRite = regs_q[sreg_q];
      end else if (state_q == WAIT || state_q == WB) begin
        arithLeft = left_q;
        arithRite = rite_q;
      end
    end
  end

endmodule

// File: tb/tb_sam_arith_dispatch.sv
// Directed plus randomized checks of sam_arith_dispatch against a register-file
// model and a behavioural stand-in for the arithmetic unit.
module tb_sam_arith_dispatch;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rsta, opValid, opReady, arithGo, arithCarry;
  logic [15:0]   opcode;
  logic [4:0]    arithSubOp;
  logic [W-1:0]  arithLeft, arithRite, regWrData, regRdData;
  logic [W:0]    arithWord;
  logic          done, illegal, carryF, zeroF, regWrEn;
  logic [2:0]    regWrAddr, regRdAddr;

  int tests_run = 0;
  int tests_failed = 0;

  logic [W-1:0] model_regs [8];
  logic         model_c, model_z;

  sam_arith_dispatch #(.TGT_BITS(W)) dut (
    .clk(clk), .rsta(rsta), .opValid(opValid), .opcode(opcode), .opReady(opReady),
    .arithGo(arithGo), .arithSubOp(arithSubOp), .arithLeft(arithLeft), .arithRite(arithRite),
    .arithWord(arithWord), .arithCarry(arithCarry), .done(done), .illegal(illegal),
    .carryF(carryF), .zeroF(zeroF), .regWrEn(regWrEn), .regWrAddr(regWrAddr),
    .regWrData(regWrData), .regRdAddr(regRdAddr), .regRdData(regRdData)
  );

  always #5 clk = ~clk;

  // Arithmetic behaviour of the external unit; bit W is the carry out.
  function automatic logic [W:0] ref_arith(input logic [4:0] s, input logic [W-1:0] l, input logic [W-1:0] r);
    logic [W:0] res;
    case (s[3:0])
      4'h0, 4'h1:       res = {1'b0, l} + {1'b0, r};
      4'h2, 4'h3, 4'h4: res = {1'b0, l} - {1'b0, r};
      4'h5:             res = {1'b0, l ^ r};
      4'h6:             res = {1'b0, l | r};
      4'h7:             res = {1'b0, l & r};
      4'h8, 4'h9:       res = {1'b0, r} - {1'b0, l};
      4'hA:             res = {1'b0, r} + 1;
      4'hB:             res = {1'b0, r} - 1;
      4'hC:             res = {r, 1'b0};
      4'hD:             res = {r[0], 1'b0, r[W-1:1]};
      4'hE:             res = {r[W-1], r[W-2:0], r[W-1]};
      default:          res = {r[0], r[0], r[W-1:1]};
    endcase
    return res;
  endfunction

  // Result is valid in the cycle after arithGo; junk otherwise so mistimed sampling shows.
  always @(posedge clk) begin
    logic [W:0]  r;
    logic [63:0] g;
    if (arithGo) begin
      r = ref_arith(arithSubOp, arithLeft, arithRite);
      arithWord  <= r;
      arithCarry <= r[W];
    end else begin
      g = {$urandom(), $urandom()};
      arithWord  <= g[W:0];
      arithCarry <= g[40];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) model_regs[i] = '0;
    model_c = 1'b0;
    model_z = 1'b0;
  endtask

  task automatic host_write(input logic [2:0] a, input logic [W-1:0] d);
    @(negedge clk);
    regWrEn = 1'b1; regWrAddr = a; regWrData = d;
    @(negedge clk);
    regWrEn = 1'b0;
    model_regs[a] = d;
  endtask

  task automatic read_chk(input string tag, input logic [2:0] a);
    regRdAddr = a;
    #1;
    check(tag, regRdData, model_regs[a]);
  endtask

  task automatic do_op(input logic [15:0] opc, input bit same_wr, input logic [2:0] wa,
                       input logic [W-1:0] wd, input bit hold_valid, input bit busy_wr);
    logic [2:0]   d, s;
    logic [4:0]   sub;
    logic [W-1:0] el, er;
    logic [W:0]   res;
    d = opc[15:13]; sub = opc[12:8]; s = opc[7:5];
    @(negedge clk);
    opValid = 1'b1; opcode = opc;
    check("ready_idle", opReady, 1);
    if (same_wr) begin
      regWrEn = 1'b1; regWrAddr = wa; regWrData = wd;
      model_regs[wa] = wd;
    end
    el = model_regs[0]; er = model_regs[s];
    res = ref_arith(sub, el, er);
    @(negedge clk);
    regWrEn = 1'b0;
    if (!hold_valid) opValid = 1'b0;
    check("issue_go", arithGo, 1);
    check("issue_subop", arithSubOp, sub);
    check("issue_left", arithLeft, el);
    check("issue_rite", arithRite, er);
    check("issue_ready", opReady, 0);
    @(negedge clk);
    check("wait_go", arithGo, 0);
    check("wait_left", arithLeft, el);
    check("wait_rite", arithRite, er);
    check("wait_subop", arithSubOp, sub);
    if (busy_wr) begin
      regWrEn = 1'b1; regWrAddr = 3'd5; regWrData = ~model_regs[5];
    end
    @(negedge clk);
    regWrEn = 1'b0;
    if (sub != 5'd4) model_regs[d] = res[W-1:0];
    model_c = res[W];
    model_z = (res[W-1:0] == '0);
    check("wb_done", done, 1);
    check("wb_go", arithGo, 0);
    check("wb_ready", opReady, 0);
    check("wb_carry", carryF, model_c);
    check("wb_zero", zeroF, model_z);
    check("wb_left", arithLeft, el);
    read_chk("wb_dreg", d);
    if (busy_wr) read_chk("busy_wr_ignored", 3'd5);
    @(negedge clk);
    opValid = 1'b0;
    check("idle_done", done, 0);
    check("idle_ready", opReady, 1);
    check("idle_left", arithLeft, 0);
    check("idle_subop", arithSubOp, 0);
    $display("[TB] op %04h dreg=%0d sreg=%0d sub=%0h -> r%0d=%08h c=%0b z=%0b", opc, d, s, sub, d,
             model_regs[d], model_c, model_z);
  endtask

  task automatic do_illegal(input logic [15:0] opc);
    @(negedge clk);
    opValid = 1'b1; opcode = opc;
    @(negedge clk);
    opValid = 1'b0;
    check("ill_pulse", illegal, 1);
    check("ill_go", arithGo, 0);
    check("ill_ready", opReady, 1);
    @(negedge clk);
    check("ill_pulse_end", illegal, 0);
    check("ill_go2", arithGo, 0);
    check("ill_carry", carryF, model_c);
    check("ill_zero", zeroF, model_z);
    for (int i = 0; i < 8; i++) read_chk("ill_regs", 3'(i));
    $display("[TB] illegal op %04h rejected", opc);
  endtask

  initial begin
    logic [15:0] o;
    logic [4:0]  t;
    rsta = 1'b1; opValid = 1'b0; opcode = '0; regWrEn = 1'b0;
    regWrAddr = '0; regWrData = '0; regRdAddr = '0;
    model_reset();

    repeat (2) @(negedge clk);
    check("rst_ready", opReady, 0);
    check("rst_go", arithGo, 0);
    check("rst_done", done, 0);
    check("rst_illegal", illegal, 0);
    check("rst_carry", carryF, 0);
    check("rst_zero", zeroF, 0);
    check("rst_left", arithLeft, 0);
    read_chk("rst_reg", 3'd3);
    rsta = 1'b0;
    #1;
    check("ready_after_rst", opReady, 1);

    // Basic ADD, carry/zero overflow, CMP without write.
    host_write(3'd0, 32'd5);
    host_write(3'd1, 32'd7);
    do_op(16'h4038, 0, 3'd0, '0, 0, 0);
    read_chk("add_r2", 3'd2);
    host_write(3'd0, 32'hFFFF_FFFF);
    host_write(3'd1, 32'd1);
    do_op(16'h4038, 0, 3'd0, '0, 0, 0);
    check("ovf_carry", carryF, 1);
    check("ovf_zero", zeroF, 1);
    host_write(3'd0, 32'd3);
    host_write(3'd1, 32'd3);
    host_write(3'd3, 32'hAA);
    do_op(16'h6438, 0, 3'd0, '0, 0, 0);
    read_chk("cmp_r3_kept", 3'd3);
    check("cmp_zero", zeroF, 1);

    do_illegal(16'h1018);

    // Busy-state host write ignored, opValid held through the operation.
    do_op(16'hA538, 0, 3'd0, '0, 1, 1);
    // Host write in the accept cycle feeds the operand read.
    do_op(16'hC058, 1, 3'd2, 32'h1234_5678, 0, 0);

    // Reset during WAIT aborts the INC.
    host_write(3'd1, 32'd9);
    @(negedge clk);
    opValid = 1'b1; opcode = 16'h2A38;
    @(negedge clk);
    opValid = 1'b0;
    check("abort_go", arithGo, 1);
    @(negedge clk);
    rsta = 1'b1;
    @(negedge clk);
    model_reset();
    check("abort_done", done, 0);
    check("abort_ready", opReady, 0);
    read_chk("abort_r1", 3'd1);
    rsta = 1'b0;
    #1;
    check("abort_ready_after", opReady, 1);
    @(negedge clk);
    check("abort_no_done", done, 0);
    $display("[TB] reset in WAIT aborted op 2A38");
    host_write(3'd1, 32'd9);
    do_op(16'h2A38, 0, 3'd0, '0, 0, 0);
    read_chk("inc_r1", 3'd1);

    for (int n = 0; n < 40; n++) begin
      for (int k = $urandom_range(0, 2); k > 0; k--)
        host_write(3'($urandom_range(0, 7)), $urandom());
      if ($urandom_range(0, 9) < 7) begin
        o = {3'($urandom_range(0, 7)), 1'b0, 4'($urandom_range(0, 15)),
             3'($urandom_range(0, 7)), 5'b11000};
        do_op(o, bit'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom(), 0, 0);
      end else begin
        o = 16'($urandom());
        if ($urandom_range(0, 1) == 1) begin
          o[12] = 1'b1;
        end else begin
          t = 5'($urandom_range(0, 30));
          if (t >= 5'd24) t = t + 5'd1;
          o[4:0] = t;
        end
        do_illegal(o);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sam_arith_dispatch.md
SAM_ARITH_DISPATCH -- requirements
Module: sam_arith_dispatch

Interface
REQ-001 SHALL have parameter TGT_BITS, default 32: register and operand width.
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-003 SHALL have port rsta, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port opValid, input, 1: opcode offered.
REQ-005 SHALL have port opcode, input, 16: fields dreg[15:13], subOp[12:8], sreg[7:5], tag[4:0].
REQ-006 SHALL have port opReady, output, 1: block can accept an opcode.
REQ-007 SHALL have ports arithGo (output, 1), arithSubOp (output, 5), arithLeft (output, TGT_BITS) and arithRite (output, TGT_BITS): issue to the arithmetic unit.
REQ-008 SHALL have ports arithWord (input, TGT_BITS+1) and arithCarry (input, 1): arithmetic result and carry.
REQ-009 SHALL have port done, output, 1: one-cycle pulse at completion.
REQ-010 SHALL have port illegal, output, 1: one-cycle pulse when a rejected opcode is accepted.
REQ-011 SHALL have ports carryF (output, 1) and zeroF (output, 1): status flags.
REQ-012 SHALL have ports regWrEn (input, 1), regWrAddr (input, 3) and regWrData (input, TGT_BITS): host write port.
REQ-013 SHALL have ports regRdAddr (input, 3) and regRdData (output, TGT_BITS): host read port, combinational.

Function
REQ-014 SHALL hold an internal register file reg0..reg7, each TGT_BITS wide.
REQ-015 SHALL use states IDLE, ISSUE, WAIT and WB; opReady SHALL be 1 only in IDLE.
REQ-016 SHALL accept an opcode on a cycle with opValid=1 and opReady=1, and SHALL latch dreg, subOp and sreg.
REQ-017 SHALL treat an opcode as legal only when tag==5'b11000 and subOp[4]==0.
REQ-018 On an illegal opcode, SHALL pulse illegal on the next cycle, issue no arithGo, make no register or flag change, and stay in IDLE.
REQ-019 On a legal opcode, SHALL go IDLE->ISSUE; in ISSUE: arithGo=1 for exactly one cycle, arithSubOp=subOp, arithLeft=reg0, arithRite=reg[sreg]; next state WAIT.
REQ-020 SHALL hold arithSubOp, arithLeft and arithRite stable from ISSUE through WB; they SHALL be 0 in IDLE.
REQ-021 In WAIT, SHALL sample arithWord and arithCarry; the arithmetic unit's result is valid one cycle after arithGo.
REQ-022 In WAIT, SHALL write reg[dreg] <= arithWord[TGT_BITS-1:0], except when subOp==4 (CMP), which performs no write.
REQ-023 In WAIT, SHALL set carryF <= arithCarry and zeroF <= (arithWord[TGT_BITS-1:0]==0) for every legal subOp, CMP included; next state WB.
REQ-024 In WB, SHALL pulse done=1 and then return to IDLE.
REQ-025 Latency: accept at cycle N; arithGo at N+1; register and flags updated at the edge ending N+2; done at N+3; next accept no earlier than N+4.
REQ-026 Operands SHALL be read in ISSUE, so dreg==sreg and dreg==0 SHALL use pre-write values.
REQ-027 SHALL honour regWrEn only in IDLE and ignore it in all other states.
REQ-028 An accept and a host write in the same IDLE cycle are both honoured; the host write SHALL be visible to the ISSUE read.
REQ-029 regRdData SHALL equal reg[regRdAddr] at all times, with no bypass.
REQ-030 subOp values: 0 ADD, 1 ADC, 2 SUB, 3 SBB, 4 CMP, 5 XOR, 6 OR, 7 AND, 8 XSUB, 9 XSBB, A INC, B DEC, C SHL, D SHR, E RCL, F RCR; all are forwarded unmodified.

Reset
REQ-031 While rsta=1: state=IDLE; reg0..reg7=0; carryF=zeroF=0; arithGo, done and illegal=0; opReady=0; arith operand outputs=0.
REQ-032 Asserting rsta in ISSUE, WAIT or WB SHALL abort the operation, with no register write and no done pulse.
REQ-033 opReady SHALL be 1 on the first cycle after rsta deasserts.

Verification
REQ-034 Host writes reg0=5 and reg1=7, then opcode 0x4038 (ADD r2) -> arithGo on cycle N+1 with left=5, rite=7; reg2=12, carryF=0, zeroF=0; done at N+3.
REQ-035 reg0=0xFFFFFFFF, reg1=1, opcode 0x4038 -> reg2=0, carryF=1, zeroF=1.
REQ-036 reg0=3, reg1=3, reg3=0xAA, opcode 0x6438 (CMP) -> reg3 stays 0xAA, zeroF=1.
REQ-037 Opcode 0x1018 (subOp 0x10) -> illegal pulse, no arithGo, registers unchanged, opReady stays 1.
REQ-038 reg1=9, opcode 0x2A38 (INC r1, dreg==sreg) with rsta pulsed in WAIT -> reg1=0 due to reset, no done; after reset, reload reg1=9 and replay 0x2A38 -> reg1=10.
REQ-039 Host write to reg5 in WAIT -> write ignored; opValid held high during busy -> no second accept until N+4.
